// File: rtl/ecc_scalar_mul.sv
// Left-to-right double-and-add scalar multiplier that sequences an external
// point add/double unit. Degenerate cases (infinity, P+(-P), P+P) are resolved here.
module ecc_scalar_mul #(
  parameter int KW = 64,
  parameter int PW = 129
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [PW-1:0] g,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] result,
  output logic          ad_enable,
  output logic [1:0]    ad_op,
  output logic [PW-1:0] ad_p,
  output logic [PW-1:0] ad_q,
  input  logic          ad_done,
  input  logic [PW-1:0] ad_T
);

  localparam int IW = (KW > 1) ? $clog2(KW) : 1;
  localparam int CW = (PW - 1) / 2;
  localparam logic [PW-1:0] INF = {1'b1, {(PW-1){1'b0}}};
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_DBL = 2'b10;

  typedef enum logic [2:0] {
    IDLE, SCAN, DBL_ISSUE, DBL_WAIT, ADD_ISSUE, ADD_WAIT, NEXT, FIN
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [KW-1:0] k_reg, k_next;
  logic [PW-1:0] g_reg, g_next;
  logic [PW-1:0] r_reg, r_next;
  logic [PW-1:0] result_reg, result_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          ad_enable_reg, ad_enable_next;
  logic [1:0]    ad_op_reg, ad_op_next;
  logic [PW-1:0] ad_p_reg, ad_p_next;
  logic [PW-1:0] ad_q_reg, ad_q_next;

  logic r_is_inf, r_y_zero, r_x_eq_g, r_y_eq_g;

  assign r_is_inf = r_reg[PW-1];
  assign r_y_zero = (r_reg[PW-2:CW] == '0);
  assign r_x_eq_g = (r_reg[CW-1:0] == g_reg[CW-1:0]);
  assign r_y_eq_g = (r_reg[PW-2:CW] == g_reg[PW-2:CW]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      k_reg         <= '0;
      g_reg         <= '0;
      r_reg         <= '0;
      result_reg    <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      ad_enable_reg <= 1'b0;
      ad_op_reg     <= '0;
      ad_p_reg      <= '0;
      ad_q_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      k_reg         <= k_next;
      g_reg         <= g_next;
      r_reg         <= r_next;
      result_reg    <= result_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      ad_enable_reg <= ad_enable_next;
      ad_op_reg     <= ad_op_next;
      ad_p_reg      <= ad_p_next;
      ad_q_reg      <= ad_q_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    k_next         = k_reg;
    g_next         = g_reg;
    r_next         = r_reg;
    result_next    = result_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    ad_enable_next = 1'b0;
    ad_op_next     = ad_op_reg;
    ad_p_next      = ad_p_reg;
    ad_q_next      = ad_q_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          k_next    = k;
          g_next    = g;
          busy_next = 1'b1;
          if (k == '0 || g[PW-1]) begin
            result_next = INF;
            state_next  = FIN;
          end else begin
            idx_next   = IW'(KW - 1);
            state_next = SCAN;
          end
        end
      end

      SCAN: begin
        if (k_reg[idx_reg]) begin
          r_next = g_reg;
          if (idx_reg == '0) begin
            result_next = g_reg;
            state_next  = FIN;
          end else begin
            idx_next   = idx_reg - 1'b1;
            state_next = DBL_ISSUE;
          end
        end else if (idx_reg == '0) begin
          // Unreachable for a nonzero scalar; fail safe to infinity.
          result_next = INF;
          state_next  = FIN;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end

      DBL_ISSUE: begin
        // Doubling infinity or a point with y = 0 yields infinity.
        if (r_is_inf || r_y_zero) begin
          r_next     = INF;
          state_next = k_reg[idx_reg] ? ADD_ISSUE : NEXT;
        end else begin
          ad_enable_next = 1'b1;
          ad_op_next     = OP_DBL;
          ad_p_next      = r_reg;
          ad_q_next      = r_reg;
          state_next     = DBL_WAIT;
        end
      end

      DBL_WAIT: begin
        if (ad_done) begin
          r_next     = ad_T;
          state_next = k_reg[idx_reg] ? ADD_ISSUE : NEXT;
        end
      end

      ADD_ISSUE: begin
        if (r_is_inf) begin
          r_next     = g_reg;
          state_next = NEXT;
        end else if (r_x_eq_g && r_y_eq_g) begin
          ad_enable_next = 1'b1;
          ad_op_next     = OP_DBL;
          ad_p_next      = g_reg;
          ad_q_next      = g_reg;
          state_next     = ADD_WAIT;
        end else if (r_x_eq_g) begin
          r_next     = INF;
          state_next = NEXT;
        end else begin
          ad_enable_next = 1'b1;
          ad_op_next     = OP_ADD;
          ad_p_next      = r_reg;
          ad_q_next      = g_reg;
          state_next     = ADD_WAIT;
        end
      end

      ADD_WAIT: begin
        if (ad_done) begin
          r_next     = ad_T;
          state_next = NEXT;
        end
      end

      NEXT: begin
        if (idx_reg == '0) begin
          result_next = r_reg;
          state_next  = FIN;
        end else begin
          idx_next   = idx_reg - 1'b1;
          state_next = DBL_ISSUE;
        end
      end

      FIN: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign result    = result_reg;
  assign ad_enable = ad_enable_reg;
  assign ad_op     = ad_op_reg;
  assign ad_p      = ad_p_reg;
  assign ad_q      = ad_q_reg;

endmodule

// File: tb/tb_ecc_scalar_mul.sv
// Scoreboard bench for ecc_scalar_mul with a fixed-latency add/double stub.
// Expected requests and results are queued by the stimulus; monitors pop and compare.
module tb_ecc_scalar_mul;

  localparam int KW = 64;
  localparam int PW = 129;
  localparam logic [PW-1:0] INF = {1'b1, 128'b0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k = '0;
  logic [PW-1:0] g = '0;
  logic          busy, done, ad_enable;
  logic [PW-1:0] result, ad_p, ad_q;
  logic [1:0]    ad_op;
  logic          ad_done = 1'b0;
  logic [PW-1:0] ad_T = '0;

  ecc_scalar_mul #(.KW(KW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k), .g(g),
    .busy(busy), .done(done), .result(result),
    .ad_enable(ad_enable), .ad_op(ad_op), .ad_p(ad_p), .ad_q(ad_q),
    .ad_done(ad_done), .ad_T(ad_T)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] op; logic [PW-1:0] p; logic [PW-1:0] q; } req_t;
  typedef struct { logic [PW-1:0] res; int lat; } res_t;

  req_t          exp_req[$];
  res_t          exp_res[$];
  logic [PW-1:0] resp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int req_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, PW'(busy), '0);
    check({tag, "_done"}, PW'(done), '0);
    check({tag, "_ad_enable"}, PW'(ad_enable), '0);
    check({tag, "_ad_op"}, PW'(ad_op), '0);
    check({tag, "_ad_p"}, ad_p, '0);
    check({tag, "_ad_q"}, ad_q, '0);
    check({tag, "_result"}, result, '0);
  endtask

  // Output monitor: results and issued requests are matched against the queues.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_res.size() == 0) begin
        check("unexpected_done", result, 'x);
      end else begin
        res_t e;
        e = exp_res.pop_front();
        check("result", result, e.res);
        if (e.lat >= 0) check("done_latency", PW'(cyc - start_cyc), PW'(e.lat));
      end
    end
    if (rst_n && ad_enable) begin
      req_cnt++;
      if (exp_req.size() == 0) begin
        check("unexpected_request_p", ad_p, 'x);
      end else begin
        req_t r;
        r = exp_req.pop_front();
        check("req_op", PW'(ad_op), PW'(r.op));
        check("req_p", ad_p, r.p);
        check("req_q", ad_q, r.q);
      end
    end
  end

  // Add/double stub: 10-cycle latency, answers from resp_q.
  initial begin : stub
    logic [1:0]    cop;
    logic [PW-1:0] cp, cq;
    bit            hold_ok, width_ok, aborted;
    forever begin
      @(negedge clk);
      if (rst_n && ad_enable) begin
        cop = ad_op; cp = ad_p; cq = ad_q;
        hold_ok = 1'b1; width_ok = 1'b1; aborted = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          if (ad_enable) width_ok = 1'b0;
          if (!aborted && (ad_op !== cop || ad_p !== cp || ad_q !== cq)) hold_ok = 1'b0;
        end
        @(posedge clk); #1;
        ad_done = 1'b1;
        if (resp_q.size() > 0) ad_T = resp_q.pop_front();
        else ad_T = '0;
        @(negedge clk);
        if (!rst_n) aborted = 1'b1;
        if (ad_enable) width_ok = 1'b0;
        if (!aborted && (ad_op !== cop || ad_p !== cp || ad_q !== cq)) hold_ok = 1'b0;
        @(posedge clk); #1;
        ad_done = 1'b0;
        ad_T = '0;
        check("enable_width", PW'(width_ok), PW'(1));
        if (!aborted) check("operand_hold", PW'(hold_ok), PW'(1));
      end
    end
  end

  task automatic do_start(input logic [KW-1:0] kv, input logic [PW-1:0] gv);
    @(posedge clk); #1;
    k = kv; g = gv; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0, i;
    n0 = done_cnt; i = 0;
    while (done_cnt == n0 && i < budget) begin
      @(negedge clk); i++;
    end
    @(negedge clk);
    if (done_cnt == n0) check({name, "_timeout"}, PW'(0), PW'(1));
    repeat (2) @(posedge clk);
  endtask

  function automatic req_t mk_req(input logic [1:0] op, input logic [PW-1:0] p, input logic [PW-1:0] q);
    req_t r;
    r.op = op; r.p = p; r.q = q;
    return r;
  endfunction

  function automatic res_t mk_res(input logic [PW-1:0] res, input int lat);
    res_t r;
    r.res = res; r.lat = lat;
    return r;
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [PW-1:0] g0, g1, t1, t2, t3, t4, neg;
    int n0;
    g0 = {1'b0, 64'h5, 64'h7};
    g1 = {1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    t1 = {1'b0, 64'hA1A1, 64'hB1B1};
    t2 = {1'b0, 64'hA2A2, 64'hB2B2};
    t3 = {1'b0, 64'hA3A3, 64'hB3B3};
    t4 = {1'b0, 64'hA4A4, 64'hB4B4};
    neg = {1'b0, ~g1[127:64], g1[63:0]};

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // k = 0 and G at infinity: immediate infinity, no requests.
    exp_res.push_back(mk_res(INF, 2));
    do_start(64'd0, g1);
    wait_done("k0", 20);
    exp_res.push_back(mk_res(INF, 2));
    do_start(64'd9, INF);
    wait_done("ginf", 20);

    // k = 1: result G after full scan.
    exp_res.push_back(mk_res(g0, 66));
    do_start(64'd1, g0);
    wait_done("k1", 200);

    // k = 5: double, double, add.
    exp_req.push_back(mk_req(2'b10, g1, g1));
    exp_req.push_back(mk_req(2'b10, t1, t1));
    exp_req.push_back(mk_req(2'b00, t2, g1));
    resp_q.push_back(t1); resp_q.push_back(t2); resp_q.push_back(t3);
    exp_res.push_back(mk_res(t3, -1));
    do_start(64'd5, g1);
    wait_done("k5", 300);

    // k = 3, 2G returned as -G: add resolves locally to infinity.
    exp_req.push_back(mk_req(2'b10, g1, g1));
    resp_q.push_back(neg);
    exp_res.push_back(mk_res(INF, -1));
    do_start(64'd3, g1);
    wait_done("k3_neg", 300);

    // k = 3, 2G returned as G: equal-point add becomes a double of G.
    exp_req.push_back(mk_req(2'b10, g1, g1));
    exp_req.push_back(mk_req(2'b10, g1, g1));
    resp_q.push_back(g1); resp_q.push_back(t4);
    exp_res.push_back(mk_res(t4, -1));
    do_start(64'd3, g1);
    wait_done("k3_eq", 300);

    // Reset during DBL_WAIT; the late ad_done must be ignored.
    exp_req.push_back(mk_req(2'b10, g1, g1));
    resp_q.push_back(t1);
    n0 = req_cnt;
    do_start(64'd5, g1);
    for (int i = 0; i < 200 && req_cnt == n0; i++) @(negedge clk);
    check("abort_request_seen", PW'(req_cnt - n0), PW'(1));
    repeat (2) @(posedge clk); #1;
    n0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("in_reset");
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_zero_outputs("after_abort");
    check("no_done_after_abort", PW'(done_cnt), PW'(n0));
    exp_res.push_back(mk_res(g0, 66));
    do_start(64'd1, g0);
    wait_done("k1_after_abort", 200);

    repeat (5) @(posedge clk);
    check("leftover_req", PW'(exp_req.size()), PW'(0));
    check("leftover_res", PW'(exp_res.size()), PW'(0));
    check("leftover_resp", PW'(resp_q.size()), PW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
